// File: rtl/pic_seq_pkg.sv
// rtl/pic_seq_pkg.sv - shared state and phase definitions for the PIC16F84 instruction sequencer
package pic_seq_pkg;

  // Instruction-cycle level state of the sequencer
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  // Phase encodings inside one instruction cycle
  localparam logic [1:0] Q1 = 2'd0;
  localparam logic [1:0] Q2 = 2'd1;
  localparam logic [1:0] Q3 = 2'd2;
  localparam logic [1:0] Q4 = 2'd3;

endpackage

// File: rtl/phase_gen.sv
// rtl/phase_gen.sv - 2-bit Q1..Q4 phase counter with freeze and registered one-hot decode
module phase_gen
  import pic_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       freeze_i,
  output logic [1:0] phase_o,
  output logic [3:0] onehot_o
);

  logic [1:0] phase_q, phase_d;
  logic [3:0] onehot_q, onehot_d;

  // Advance the phase (wrapping Q4 -> Q1) unless frozen; decode ahead so strobes come from flops
  always_comb begin
    phase_d  = freeze_i ? phase_q : phase_q + 2'd1;
    onehot_d = 4'b0001 << phase_d;
  end

  // Phase and one-hot strobe registers; reset parks the counter at Q4 so the first edge lands on Q1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q  <= Q4;
      onehot_q <= 4'b1000;
    end else begin
      phase_q  <= phase_d;
      onehot_q <= onehot_d;
    end
  end

  assign phase_o  = phase_q;
  assign onehot_o = onehot_q;

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - single-clock Q1..Q4 instruction-cycle controller with flush and hold
module instr_sequencer
  import pic_seq_pkg::*;
(
  input  logic       master_clk,
  input  logic       reset_n,
  input  logic       is_branch,
  input  logic       writes_result,
  input  logic       dest_f,
  input  logic       skip_cond,
  input  logic       hold,
  output logic [1:0] phase,
  output logic       q1,
  output logic       q2,
  output logic       q3,
  output logic       q4,
  output logic       f_rd_en,
  output logic       alu_en,
  output logic       w_we,
  output logic       f_we,
  output logic       ir_load,
  output logic       pc_en,
  output logic       pc_load,
  output logic       exec_valid
);

  seq_state_e state_q, state_d;
  seq_state_e pend_q, pend_d;
  seq_state_e nxt_cyc;
  logic [1:0] phase_q;
  logic [3:0] onehot;
  logic       freeze;
  logic       active;
  logic       in_exec;

  // The phase freezes whenever the sequencer is (or stays) parked in HOLD
  assign freeze = (state_d == ST_HOLD);

  phase_gen u_phase_gen (
    .clk_i    (master_clk),
    .rst_ni   (reset_n),
    .freeze_i (freeze),
    .phase_o  (phase_q),
    .onehot_o (onehot)
  );

  // Next-cycle decision: a branch or skip forces one FLUSH cycle; hold at Q4 parks the decision
  always_comb begin
    nxt_cyc = ((state_q == ST_EXEC) && (is_branch || skip_cond)) ? ST_FLUSH : ST_EXEC;
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      ST_RESET: state_d = ST_FLUSH;
      ST_EXEC, ST_FLUSH: begin
        if (phase_q == Q4) begin
          if (hold) begin
            state_d = ST_HOLD;
            pend_d  = nxt_cyc;
          end else begin
            state_d = nxt_cyc;
          end
        end
      end
      ST_HOLD: begin
        if (!hold) state_d = pend_q;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // State and latched post-hold state; async clear kills every enable immediately
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RESET;
      pend_q  <= ST_FLUSH;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign active  = (state_q == ST_EXEC) || (state_q == ST_FLUSH);
  assign in_exec = (state_q == ST_EXEC);

  assign phase      = phase_q;
  assign q1         = onehot[0] & active;
  assign q2         = onehot[1] & active;
  assign q3         = onehot[2] & active;
  assign q4         = onehot[3] & active;
  assign f_rd_en    = q2 & in_exec;
  assign alu_en     = q3 & in_exec;
  assign w_we       = q4 & in_exec & writes_result & ~dest_f;
  assign f_we       = q4 & in_exec & writes_result & dest_f;
  assign pc_load    = q4 & in_exec & is_branch;
  assign ir_load    = q4;
  assign pc_en      = q4 & ~pc_load;
  assign exec_valid = in_exec;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic       master_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       is_branch = 1'b0;
  logic       writes_result = 1'b0;
  logic       dest_f = 1'b0;
  logic       skip_cond = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] phase;
  logic       q1, q2, q3, q4;
  logic       f_rd_en, alu_en, w_we, f_we, ir_load, pc_en, pc_load, exec_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 master_clk = ~master_clk;

  instr_sequencer dut (
    .master_clk    (master_clk),
    .reset_n       (reset_n),
    .is_branch     (is_branch),
    .writes_result (writes_result),
    .dest_f        (dest_f),
    .skip_cond     (skip_cond),
    .hold          (hold),
    .phase         (phase),
    .q1            (q1),
    .q2            (q2),
    .q3            (q3),
    .q4            (q4),
    .f_rd_en       (f_rd_en),
    .alu_en        (alu_en),
    .w_we          (w_we),
    .f_we          (f_we),
    .ir_load       (ir_load),
    .pc_en         (pc_en),
    .pc_load       (pc_load),
    .exec_valid    (exec_valid)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge master_clk);
    #1;
  endtask

  function automatic logic [7:0] strobes();
    return {4'd0, q4, q3, q2, q1};
  endfunction

  // Twelve edges after reset release: one FLUSH cycle then EXEC cycles, no writes/branches
  task automatic powerup(input string pfx);
    for (int n = 1; n <= 12; n++) begin
      logic [1:0] ph;
      step();
      #1;
      ph = 2'((n - 1) % 4);
      chk($sformatf("%s_phase_%0d", pfx, n), 8'(phase), 8'(ph));
      chk($sformatf("%s_strb_%0d", pfx, n), strobes(), 8'(4'b0001 << ph));
      chk($sformatf("%s_ev_%0d", pfx, n), 8'(exec_valid), 8'(n >= 5));
      chk($sformatf("%s_ir_%0d", pfx, n), 8'(ir_load), 8'(n % 4 == 0));
      chk($sformatf("%s_pcen_%0d", pfx, n), 8'(pc_en), 8'(n % 4 == 0));
      chk($sformatf("%s_rd_%0d", pfx, n), 8'(f_rd_en), 8'(n >= 5 && ph == 2'd1));
      chk($sformatf("%s_alu_%0d", pfx, n), 8'(alu_en), 8'(n >= 5 && ph == 2'd2));
      chk($sformatf("%s_pcld_%0d", pfx, n), 8'(pc_load), 8'd0);
    end
  endtask

  // One full instruction cycle with fixed inputs; ev says whether it is expected to be EXEC
  task automatic cycle(input logic br, input logic sk, input logic wr, input logic df,
                       input logic ev, input string tag);
    for (int p = 0; p < 4; p++) begin
      step();
      is_branch = br;
      skip_cond = sk;
      writes_result = wr;
      dest_f = df;
      #1;
      chk($sformatf("%s_phase_%0d", tag, p), 8'(phase), 8'(p));
      chk($sformatf("%s_strb_%0d", tag, p), strobes(), 8'(1 << p));
      chk($sformatf("%s_ev_%0d", tag, p), 8'(exec_valid), 8'(ev));
      chk($sformatf("%s_wwe_%0d", tag, p), 8'(w_we), 8'(p == 3 && ev && wr && !df));
      chk($sformatf("%s_fwe_%0d", tag, p), 8'(f_we), 8'(p == 3 && ev && wr && df));
      chk($sformatf("%s_pcld_%0d", tag, p), 8'(pc_load), 8'(p == 3 && ev && br));
      chk($sformatf("%s_pcen_%0d", tag, p), 8'(pc_en), 8'(p == 3 && !(ev && br)));
      chk($sformatf("%s_ir_%0d", tag, p), 8'(ir_load), 8'(p == 3));
    end
  endtask

  initial begin
    repeat (3) step();
    chk("rst_phase", 8'(phase), 8'd3);
    chk("rst_strb", strobes(), 8'd0);
    chk("rst_ev", 8'(exec_valid), 8'd0);
    chk("rst_ir", 8'(ir_load), 8'd0);
    chk("rst_pcen", 8'(pc_en), 8'd0);
    reset_n = 1'b1;
    powerup("pu");

    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "wr_w");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "wr_f");
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "no_wr");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "br");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "br_flush");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "post_br");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "br_skip");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bs_flush");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "post_bs");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "skip");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "skip_flush");

    // EXEC cycle with a skip; hold raised from Q2 must not stall until Q4
    for (int p = 0; p < 4; p++) begin
      step();
      skip_cond = 1'b1;
      hold = (p >= 1);
      #1;
      chk($sformatf("hsk_phase_%0d", p), 8'(phase), 8'(p));
      chk($sformatf("hsk_ev_%0d", p), 8'(exec_valid), 8'd1);
    end
    // Seven clocks parked in HOLD
    for (int k = 0; k < 7; k++) begin
      step();
      skip_cond = 1'b0;
      hold = (k < 6);
      #1;
      chk($sformatf("hold_phase_%0d", k), 8'(phase), 8'd3);
      chk($sformatf("hold_strb_%0d", k), strobes(), 8'd0);
      chk($sformatf("hold_ev_%0d", k), 8'(exec_valid), 8'd0);
      chk($sformatf("hold_ir_%0d", k), 8'(ir_load), 8'd0);
      chk($sformatf("hold_pcen_%0d", k), 8'(pc_en), 8'd0);
    end
    // Pending flush from the skip is honoured after the hold
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hold_flush");

    // Reset pulse during Q3 of an EXEC cycle that would write W
    for (int p = 0; p < 3; p++) begin
      step();
      writes_result = 1'b1;
      dest_f = 1'b0;
      #1;
      chk($sformatf("rx_phase_%0d", p), 8'(phase), 8'(p));
      chk($sformatf("rx_ev_%0d", p), 8'(exec_valid), 8'd1);
    end
    chk("rx_alu", 8'(alu_en), 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rx_async_phase", 8'(phase), 8'd3);
    chk("rx_async_strb", strobes(), 8'd0);
    chk("rx_async_ev", 8'(exec_valid), 8'd0);
    chk("rx_async_alu", 8'(alu_en), 8'd0);
    step();
    chk("rx_wwe", 8'(w_we), 8'd0);
    chk("rx_fwe", 8'(f_we), 8'd0);
    chk("rx_phase", 8'(phase), 8'd3);
    writes_result = 1'b0;
    reset_n = 1'b1;
    powerup("re");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Single-clock instruction-cycle controller for the PIC16F84 core. It replaces the four derived phase clocks with Q1–Q4 one-cycle enable strobes on `master_clk`, and drives the datapath from those strobes: fetch/PC advance, register read, ALU evaluate and write-back. It also inserts the forced-NOP cycle needed after taken branches and skips, and supports a hold (sleep) request. It sits between `decode`/ALU status and the `pc`, `instruction_register`, `registers` and `w_register` blocks.

## Interface
Parameters:
- none

Ports:
- `master_clk` in 1 — sole clock; all state on rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `is_branch` in 1 — executing instruction is GOTO/CALL/RETURN/RETLW/RETFIE; valid Q1–Q4
- `writes_result` in 1 — executing instruction produces a result
- `dest_f` in 1 — d bit: 1 = file register, 0 = W
- `skip_cond` in 1 — skip test true (DECFSZ/INCFSZ/BTFSx); valid by Q4
- `hold` in 1 — sleep/stall request, sampled only in Q4
- `phase` out 2 — current phase, 0..3 = Q1..Q4
- `q1`,`q2`,`q3`,`q4` out 1 each — one-hot phase strobes
- `f_rd_en` out 1 — register file read (Q2, exec cycles)
- `alu_en` out 1 — ALU evaluate (Q3, exec cycles)
- `w_we` out 1 — W write (Q4)
- `f_we` out 1 — file register write (Q4)
- `ir_load` out 1 — IR captures program memory (Q4)
- `pc_en` out 1 — PC increment (Q4)
- `pc_load` out 1 — PC loads branch target (Q4)
- `exec_valid` out 1 — current cycle executes a real instruction

## Operation
- FSM states: RESET, EXEC, FLUSH, HOLD. Phase counter is 2 bits and wraps 3→0.
- Reset values: state = RESET, phase = 3. All strobes and enables are 0. `exec_valid` = 0.
- First edge after `reset_n` rises: phase = 0, state = FLUSH. The IR is empty, so the first cycle only fetches address 0.
- Strobes are suppressed in HOLD and RESET. Otherwise:
  - `q1`..`q4` follow phase.
  - `ir_load` fires every Q4 of EXEC or FLUSH.
  - `pc_en` fires every Q4 of EXEC or FLUSH, unless `pc_load` fires.
- Exec-only enables, active when state = EXEC:
  - `f_rd_en` = Q2.
  - `alu_en` = Q3.
  - `w_we` = Q4 & `writes_result` & !`dest_f`.
  - `f_we` = Q4 & `writes_result` & `dest_f`.
- `pc_load` = Q4 & EXEC & `is_branch`.
- Next-cycle decision is made at Q4:
  - EXEC & `is_branch` → next cycle is FLUSH. The sequentially fetched IR content is discarded.
  - EXEC & `skip_cond` (no branch) → next cycle is FLUSH. PC increments normally.
  - `is_branch` and `skip_cond` both set → branch wins. There is one FLUSH, not two.
  - Otherwise → EXEC.
- `hold` = 1 at Q4 → enter HOLD after that Q4. The pending flush flag is latched and the phase freezes at 3.
- `hold` = 0 in HOLD → the next edge starts Q1 of the latched next state (EXEC or FLUSH).
- `exec_valid` = 1 exactly when state = EXEC.

## Timing
- Instruction cycle = 4 `master_clk` cycles. Strobes are registered outputs, high for exactly one clock.
- Pipeline: an instruction fetched at Q4 of cycle N executes in cycle N+1.
- First real instruction (address 0) executes in cycles 5–8 after reset release.
- A taken branch costs 2 instruction cycles: EXEC then FLUSH. At Q4 of the FLUSH cycle the IR loads mem[target] and the PC becomes target+1.
- `hold` asserted outside Q4 is ignored until the next Q4. Minimum HOLD length is 1 clock.
- `reset_n` low at any phase clears all outputs combinationally via the async flops, with no partial write-back. Recovery is identical to power-up.

## Structure
- Package `pic_seq_pkg` holds:
  - the state enum (RESET, EXEC, FLUSH, HOLD);
  - phase constants Q1..Q4 = 0..3.
- One sub-module, `phase_gen`: the 2-bit phase counter with freeze input and one-hot decode. The FSM and enable logic live in `instr_sequencer`.

## Test plan
- Reset release, `hold`=0, no branches → phase 0,1,2,3 repeating; first cycle `exec_valid`=0; `ir_load`/`pc_en` at clocks 4, 8, 12; `exec_valid`=1 from clock 5.
- EXEC with `writes_result`=1 → `dest_f`=0 gives `w_we` only at Q4; `dest_f`=1 gives `f_we` only; `writes_result`=0 gives neither.
- `is_branch`=1 in an EXEC cycle → `pc_load`=1 and `pc_en`=0 at its Q4; following cycle has `exec_valid`=0 and `pc_en`=1 at Q4.
- `skip_cond`=1 together with `is_branch`=1 → exactly one FLUSH cycle; `pc_load` once.
- `hold`=1 at Q4 for 7 clocks → no strobes and phase stuck at 3; Q1 occurs on the first edge after `hold` falls; a pending flush is still honoured.
- `reset_n` pulsed low during Q3 of an EXEC cycle → no `w_we`/`f_we`; outputs 0 immediately; restart sequence identical to power-up.
